// File: rtl/debounce_entradas_if.sv
// debounce_entradas_if: groups the raw button levels and the debounced
// outputs of debounce_entradas. The master side (stimulus/upstream) drives
// iBotones; the slave side (debouncer) drives oA and oCambio.
interface debounce_entradas_if #(
   parameter int ANCHO = 3
);
   logic [ANCHO-1:0] iBotones;
   logic [ANCHO-1:0] oA;
   logic             oCambio;

   modport master (
      output iBotones,
      input  oA,
      input  oCambio
   );

   modport slave (
      input  iBotones,
      output oA,
      output oCambio
   );
endinterface

// File: rtl/debounce_entradas.sv
// debounce_entradas: per-channel switch debouncer.
// Each channel accepts a new level only after the sampled input has differed
// from the current debounced level for CICLOS_ESTABLES consecutive cycles.
// oCambio is a registered strobe aligned with every update of oA.
// Optional macro DEBOUNCE_SINCRONIZADOR_EN: inserts a 2-flop synchronizer in
// front of each channel (adds two cycles of latency). Without it the inputs
// are assumed to be synchronous to iClk already.
module debounce_entradas #(
   parameter int ANCHO           = 3,
   parameter int CICLOS_ESTABLES = 4
) (
   input logic             iClk,
   input logic             iReset,
   debounce_entradas_if.slave bus
);

   // Counter only needs to reach CICLOS_ESTABLES-1, it never wraps.
   localparam int CW = (CICLOS_ESTABLES > 2) ? $clog2(CICLOS_ESTABLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(CICLOS_ESTABLES - 1);

   logic [ANCHO-1:0] muestra;
   logic [ANCHO-1:0] nivel;
   logic             cambio;
   logic [CW-1:0]    cnt      [ANCHO];
   logic [CW-1:0]    cnt_next [ANCHO];
   logic [ANCHO-1:0] carga;

`ifdef DEBOUNCE_SINCRONIZADOR_EN
   logic [ANCHO-1:0] sinc_a;
   logic [ANCHO-1:0] sinc_b;

   // Two-flop synchronizer; held at zero during reset so inputs are ignored.
   always_ff @(posedge iClk) begin
      if (iReset) begin
         sinc_a <= '0;
         sinc_b <= '0;
      end else begin
         sinc_a <= bus.iBotones;
         sinc_b <= sinc_a;
      end
   end

   assign muestra = sinc_b;
`else
   assign muestra = bus.iBotones;
`endif

   // Per-channel qualification: count while the sample disagrees with the
   // debounced level, load on the cycle the count is already at its maximum.
   always_comb begin
      carga = '0;
      for (int k = 0; k < ANCHO; k++) begin
         cnt_next[k] = '0;
         if (muestra[k] != nivel[k]) begin
            if (cnt[k] == CNT_MAX) begin
               carga[k]    = 1'b1;
               cnt_next[k] = '0;
            end else begin
               cnt_next[k] = cnt[k] + 1'b1;
            end
         end
      end
   end

   // State update: counters, debounced levels and the aligned change strobe.
   always_ff @(posedge iClk) begin
      if (iReset) begin
         nivel  <= '0;
         cambio <= 1'b0;
         for (int k = 0; k < ANCHO; k++) begin
            cnt[k] <= '0;
         end
      end else begin
         for (int k = 0; k < ANCHO; k++) begin
            cnt[k] <= cnt_next[k];
            if (carga[k]) begin
               nivel[k] <= muestra[k];
            end
         end
         cambio <= |carga;
      end
   end

   assign bus.oA      = nivel;
   assign bus.oCambio = cambio;

endmodule

// File: tb/tb_debounce_entradas.sv
// tb_debounce_entradas: directed scenarios plus randomized bouncing inputs,
// checked every cycle against a history-based reference model: a channel
// takes a new level once its last CICLOS_ESTABLES samples (since reset) all
// disagree with the current debounced level.
module tb_debounce_entradas;

   localparam int ANCHO = 3;
   localparam int N     = 4;
`ifdef DEBOUNCE_SINCRONIZADOR_EN
   localparam int LAT = N + 2;
`else
   localparam int LAT = N;
`endif

   logic iClk;
   logic iReset;

   int compared   = 0;
   int mismatched = 0;

   debounce_entradas_if #(.ANCHO(ANCHO)) bus ();

   debounce_entradas #(
      .ANCHO           (ANCHO),
      .CICLOS_ESTABLES (N)
   ) dut (
      .iClk   (iClk),
      .iReset (iReset),
      .bus    (bus)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [ANCHO-1:0] m_oA     = '0;
   logic             m_cambio = 1'b0;
   logic [ANCHO-1:0] m_s1     = '0;
   logic [ANCHO-1:0] m_s2     = '0;
   logic [ANCHO-1:0] hist[$];

   always @(posedge iClk) begin
      logic [ANCHO-1:0] s;
      logic [ANCHO-1:0] nxt;
      bit todos;
      if (iReset) begin
         m_oA = '0;
         m_cambio = 1'b0;
         m_s1 = '0;
         m_s2 = '0;
         hist.delete();
      end else begin
`ifdef DEBOUNCE_SINCRONIZADOR_EN
         s = m_s2;
         m_s2 = m_s1;
         m_s1 = bus.iBotones;
`else
         s = bus.iBotones;
`endif
         hist.push_back(s);
         if (hist.size() > N) void'(hist.pop_front());
         nxt = m_oA;
         if (hist.size() == N) begin
            for (int k = 0; k < ANCHO; k++) begin
               todos = 1'b1;
               for (int i = 0; i < N; i++)
                  if (hist[i][k] == m_oA[k]) todos = 1'b0;
               if (todos) nxt[k] = ~m_oA[k];
            end
         end
         m_cambio = (nxt != m_oA);
         m_oA = nxt;
      end
      #1;
      check("model_oA", 32'(bus.oA), 32'(m_oA));
      check("model_oCambio", 32'(bus.oCambio), 32'(m_cambio));
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_reset();
      @(negedge iClk);
      iReset = 1'b1;
      bus.iBotones = '0;
      @(negedge iClk);
      iReset = 1'b0;
   endtask

   task automatic set_in(input logic [ANCHO-1:0] v);
      @(negedge iClk);
      bus.iBotones = v;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int n_cambio;
      bit pat[10];
      iReset = 1'b1;
      bus.iBotones = '0;
      pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

      // Reset state
      repeat (2) @(posedge iClk);
      #1;
      check("reset_oA", 32'(bus.oA), 32'h0);
      check("reset_oCambio", 32'(bus.oCambio), 32'h0);
      @(negedge iClk);
      iReset = 1'b0;

      // 000 -> 001 held: update exactly LAT cycles after the change
      do_reset();
      set_in(3'b001);
      repeat (LAT - 1) @(posedge iClk);
      #1 check("single_before", 32'(bus.oA), 32'h0);
      @(posedge iClk);
      #1 check("single_oA", 32'(bus.oA), 32'h1);
      check("single_cambio", 32'(bus.oCambio), 32'h1);
      @(posedge iClk);
      #1 check("single_cambio_off", 32'(bus.oCambio), 32'h0);

      // Three-cycle glitch on bit1 is filtered
      do_reset();
      set_in(3'b010);
      set_in(3'b010);
      set_in(3'b010);
      set_in(3'b000);
      n_cambio = 0;
      repeat (12) begin
         @(posedge iClk);
         #1 if (bus.oCambio) n_cambio++;
      end
      check("glitch_oA", 32'(bus.oA), 32'h0);
      check("glitch_cambios", 32'(n_cambio), 32'h0);

      // Two channels together: one update, one strobe
      do_reset();
      set_in(3'b101);
      n_cambio = 0;
      for (int i = 1; i <= LAT + 3; i++) begin
         @(posedge iClk);
         #1;
         if (bus.oCambio) n_cambio++;
         if (i == LAT - 1) check("dual_before", 32'(bus.oA), 32'h0);
         if (i == LAT) check("dual_oA", 32'(bus.oA), 32'h5);
      end
      check("dual_cambios", 32'(n_cambio), 32'h1);

      // Bounce on bit2: only the final stable run (starting at index 5) counts
      do_reset();
      for (int j = 1; j <= 5 + LAT + 1; j++) begin
         @(negedge iClk);
         bus.iBotones = (j - 1 < 10) ? {pat[j-1], 2'b00} : 3'b100;
         @(posedge iClk);
         #1;
         if (j == 5 + LAT - 1) check("bounce_before", 32'(bus.oA[2]), 32'h0);
         if (j == 5 + LAT) check("bounce_rise", 32'(bus.oA[2]), 32'h1);
      end

      // Reset in the middle of a count discards it
      do_reset();
      set_in(3'b111);
      repeat (3) @(posedge iClk);
      @(negedge iClk);
      iReset = 1'b1;
      @(posedge iClk);
      #1 check("midreset_oA", 32'(bus.oA), 32'h0);
      @(negedge iClk);
      iReset = 1'b0;
      for (int i = 1; i <= LAT; i++) begin
         @(posedge iClk);
         #1;
         if (i == LAT - 1) check("after_reset_before", 32'(bus.oA), 32'h0);
         if (i == LAT) check("after_reset_oA", 32'(bus.oA), 32'h7);
      end

      // Falling edge behaves like the rising one
      set_in(3'b000);
      for (int i = 1; i <= LAT; i++) begin
         @(posedge iClk);
         #1;
         if (i == LAT - 1) check("fall_before", 32'(bus.oA), 32'h7);
         if (i == LAT) check("fall_oA", 32'(bus.oA), 32'h0);
      end

      // Randomized bouncing with occasional resets
      for (int c = 0; c < 3000; c++) begin
         @(negedge iClk);
         iReset = ($urandom_range(0, 299) == 0);
         for (int k = 0; k < ANCHO; k++)
            if ($urandom_range(0, 5) == 0) bus.iBotones[k] = ~bus.iBotones[k];
      end
      @(negedge iClk);
      iReset = 1'b0;
      repeat (3) @(posedge iClk);
      #2;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/debounce_entradas.md
DEBOUNCE_ENTRADAS -- requirements
Module: debounce_entradas

Interface
REQ-001 SHALL have parameter ANCHO, default 3, number of independent input channels.
REQ-002 SHALL have parameter CICLOS_ESTABLES, default 4, consecutive stable cycles required to accept a new level; legal range 2..255.
REQ-003 SHALL have port iClk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port iReset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port iBotones  input  ANCHO  raw, asynchronous, bouncing switch/button levels.
REQ-006 SHALL have port oA  output  ANCHO  debounced levels, registered; drives the downstream gate stage's iA input.
REQ-007 SHALL have port oCambio  output  1  one-cycle strobe, high in the cycle in which any bit of oA takes a new value.

Function
REQ-008 SHALL process each channel k independently, using a sampled level s[k] and a counter cnt[k] of width ceil(log2(CICLOS_ESTABLES)).
REQ-009 SHALL, every cycle with s[k]==oA[k], clear cnt[k] to 0 and hold oA[k].
REQ-010 SHALL, every cycle with s[k]!=oA[k] and cnt[k]<CICLOS_ESTABLES-1, increment cnt[k] by 1.
REQ-011 SHALL, every cycle with s[k]!=oA[k] and cnt[k]==CICLOS_ESTABLES-1, load oA[k]<=s[k] and clear cnt[k] to 0.
REQ-012 SHALL filter out any excursion of s[k] shorter than CICLOS_ESTABLES cycles; oA[k] SHALL not change, and cnt[k] SHALL restart from 0 on return.
REQ-013 SHALL never wrap cnt[k]; its maximum value is CICLOS_ESTABLES-1.
REQ-014 SHALL register oCambio as the OR of all per-channel load events of REQ-011, so oCambio and the new oA value appear in the same cycle.
REQ-015 SHALL, when several channels load in the same cycle, update all of them together and raise oCambio for exactly one cycle.
REQ-016 SHALL, when a channel loads in consecutive cycles due to a real level change, assert oCambio in each of those cycles.
REQ-017 SHALL treat rising and falling transitions identically.

Reset
REQ-018 SHALL, while iReset is high at a rising edge of iClk, set oA=0, oCambio=0, all cnt[k]=0 and all synchronizer flops=0.
REQ-019 SHALL, on reset asserted mid-count, discard every pending count; after release, a level differing from 0 needs a full new qualification per REQ-011.
REQ-020 SHALL ignore iBotones while iReset is high.

Configuration
REQ-021 SHALL, with macro DEBOUNCE_SINCRONIZADOR_EN defined, pass each iBotones bit through a 2-flop synchronizer, with s[k] being the second flop; latency from a stable iBotones change to oA equals CICLOS_ESTABLES+2 cycles.
REQ-022 SHALL, with DEBOUNCE_SINCRONIZADOR_EN undefined, use s[k]=iBotones[k] directly (inputs already synchronous); latency equals CICLOS_ESTABLES cycles.

Verification
REQ-023 SHALL cover: macro defined, CICLOS_ESTABLES=4, reset then iBotones 000->001 held 10 cycles -> oA=001 and oCambio=1 exactly at cycle 6 after the change, oCambio=0 at cycle 7.
REQ-024 SHALL cover: iBotones[1] pulsed high for 3 cycles, then low -> oA stays 000, oCambio never asserted.
REQ-025 SHALL cover: iBotones 000->101 in the same cycle, held -> oA goes 000->101 in a single cycle with one oCambio pulse.
REQ-026 SHALL cover: bounce pattern 1,0,1,1,0,1,1,1,1,1 on bit2 -> oA[2] rises only after the final 4-cycle stable run, at cycle 2+4 after its start.
REQ-027 SHALL cover: iBotones=111 held, iReset pulsed at cycle 3 of the count -> oA=000 during reset, then oA=111 at cycle 6 after reset release.
REQ-028 SHALL cover: macro undefined, 000->010 held -> oA=010 and oCambio=1 at cycle 4; release to 000 -> oA=000 four cycles later.
